// File: rtl/riscv_pkg.sv
// Shared constants and types for the multicycle RV64 subset control path:
// opcodes, FSM state encodings, aluOp codes, aluSrcB selects, control word.
package riscv_pkg;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_RS2  = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM  = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_TRAP     = 4'd9
    } state_t;

    // One control word; every field defaults to 0 in each state.
    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       pcSource;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memToReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic       instrDone;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the main control FSM (master) and the datapath (slave).
// memReady handshake: the controller holds memRead or memWrite high in a
// memory state until a cycle in which memReady=1; that cycle completes the
// access and the FSM advances on the following edge. memReady seen in any
// other state has no effect.
interface multicycle_control_if;
    import riscv_pkg::*;

    logic [6:0] opcode;
    logic       memReady;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       pcSource;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       instrDone;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, memReady,
        output pcWrite, pcWriteCond, pcSource, iorD, memRead, memWrite,
               irWrite, memToReg, regWrite, aluSrcA, aluSrcB, aluOp,
               instrDone, illegal, state
    );

    modport slave (
        output opcode, memReady,
        input  pcWrite, pcWriteCond, pcSource, iorD, memRead, memWrite,
               irWrite, memToReg, regWrite, aluSrcA, aluSrcB, aluOp,
               instrDone, illegal, state
    );

endinterface

// File: rtl/multicycle_control_decode.sv
// Purely combinational state -> control word table. memReady only gates
// the FETCH IR/PC load and the store retire pulse.
module multicycle_control_decode
    import riscv_pkg::*;
(
    input  state_t state,
    input  logic   memReady,
    output ctrl_t  ctrl
);

    // Control word lookup; unlisted fields stay 0.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.memRead  = 1'b1;
                ctrl.iorD     = 1'b0;
                ctrl.aluSrcA  = 1'b0;
                ctrl.aluSrcB  = ALUSRCB_FOUR;
                ctrl.aluOp    = ALUOP_ADD;
                ctrl.pcSource = 1'b0;
                ctrl.irWrite  = memReady;
                ctrl.pcWrite  = memReady;
            end
            S_DECODE: begin
                // PC + imm lands in ALUOut as the branch target.
                ctrl.aluSrcA = 1'b0;
                ctrl.aluSrcB = ALUSRCB_IMM;
                ctrl.aluOp   = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = ALUSRCB_IMM;
                ctrl.aluOp   = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.memRead = 1'b1;
                ctrl.iorD    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regWrite  = 1'b1;
                ctrl.memToReg  = 1'b1;
                ctrl.instrDone = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.memWrite  = 1'b1;
                ctrl.iorD      = 1'b1;
                ctrl.instrDone = memReady;
            end
            S_EXECUTE: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = ALUSRCB_RS2;
                ctrl.aluOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.regWrite  = 1'b1;
                ctrl.memToReg  = 1'b0;
                ctrl.instrDone = 1'b1;
            end
            S_BRANCH: begin
                ctrl.aluSrcA     = 1'b1;
                ctrl.aluSrcB     = ALUSRCB_RS2;
                ctrl.aluOp       = ALUOP_SUB;
                ctrl.pcWriteCond = 1'b1;
                ctrl.pcSource    = 1'b1;
                ctrl.instrDone   = 1'b1;
            end
            S_TRAP: begin
                ctrl.illegal = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore main control FSM for the multicycle core (ld, sd, add/sub/and/or,
// beq). Holds the state register and next-state logic; outputs come from
// the decode table.
module multicycle_control
    import riscv_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    // State register; reset returns to FETCH from anywhere, including TRAP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; TRAP only leaves on reset, bad encodings fall into it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (bus.memReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_LD, OP_SD: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                if (bus.opcode == OP_LD)      state_d = S_MEMREAD;
                else if (bus.opcode == OP_SD) state_d = S_MEMWRITE;
                else                          state_d = S_TRAP;
            end
            S_MEMREAD: begin
                if (bus.memReady) state_d = S_MEMWB;
            end
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: begin
                if (bus.memReady) state_d = S_FETCH;
            end
            S_EXECUTE:  state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    multicycle_control_decode u_decode (
        .state    (state_q),
        .memReady (bus.memReady),
        .ctrl     (ctrl)
    );

    assign bus.pcWrite     = ctrl.pcWrite;
    assign bus.pcWriteCond = ctrl.pcWriteCond;
    assign bus.pcSource    = ctrl.pcSource;
    assign bus.iorD        = ctrl.iorD;
    assign bus.memRead     = ctrl.memRead;
    assign bus.memWrite    = ctrl.memWrite;
    assign bus.irWrite     = ctrl.irWrite;
    assign bus.memToReg    = ctrl.memToReg;
    assign bus.regWrite    = ctrl.regWrite;
    assign bus.aluSrcA     = ctrl.aluSrcA;
    assign bus.aluSrcB     = ctrl.aluSrcB;
    assign bus.aluOp       = ctrl.aluOp;
    assign bus.instrDone   = ctrl.instrDone;
    assign bus.illegal     = ctrl.illegal;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: the driver pushes the hand-written
// expected control word for each cycle; a negedge monitor pops and compares.
module tb_multicycle_control;

    localparam logic [6:0] T_LD  = 7'b0000011;
    localparam logic [6:0] T_SD  = 7'b0100011;
    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_BEQ = 7'b1100011;
    localparam logic [6:0] T_BAD = 7'b1111111;

    // Word layout: state[19:16] pcWrite pcWriteCond pcSource iorD memRead
    // memWrite irWrite memToReg regWrite aluSrcA aluSrcB[5:4] aluOp[3:2]
    // instrDone illegal
    function automatic logic [19:0] mk(
        input logic [3:0] st, input logic pcw, input logic pcc,
        input logic pcs, input logic iord, input logic mrd, input logic mwr,
        input logic irw, input logic m2r, input logic rw, input logic asa,
        input logic [1:0] asb, input logic [1:0] aop, input logic done,
        input logic ill);
        return {st, pcw, pcc, pcs, iord, mrd, mwr, irw, m2r, rw, asa, asb, aop, done, ill};
    endfunction

    //                                 st  pcw pcc pcs iod mrd mwr irw m2r rw asa asb    aop   dn ill
    localparam logic [19:0] W_FETCH_GO = mk(4'd0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2'b01, 2'b00, 0, 0);
    localparam logic [19:0] W_FETCH_WT = mk(4'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
    localparam logic [19:0] W_DECODE   = mk(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0);
    localparam logic [19:0] W_MEMADR   = mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0);
    localparam logic [19:0] W_MEMREAD  = mk(4'd3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    localparam logic [19:0] W_MEMWB    = mk(4'd4, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 1, 0);
    localparam logic [19:0] W_MEMWR_GO = mk(4'd5, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
    localparam logic [19:0] W_MEMWR_WT = mk(4'd5, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    localparam logic [19:0] W_EXECUTE  = mk(4'd6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0, 0);
    localparam logic [19:0] W_ALUWB    = mk(4'd7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0);
    localparam logic [19:0] W_BRANCH   = mk(4'd8, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 1, 0);
    localparam logic [19:0] W_TRAP     = mk(4'd9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1);

    // Clock and reset
    logic clk;
    logic reset;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Scoreboard state
    logic [19:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cycle_no = 0;

    wire [19:0] act_word = {bus.state, bus.pcWrite, bus.pcWriteCond,
                            bus.pcSource, bus.iorD, bus.memRead,
                            bus.memWrite, bus.irWrite, bus.memToReg,
                            bus.regWrite, bus.aluSrcA, bus.aluSrcB,
                            bus.aluOp, bus.instrDone, bus.illegal};

    // Monitor: one expected word per driven cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [19:0] exp_w;
            exp_w = exp_q.pop_front();
            checks++;
            if (act_word !== exp_w) begin
                failures++;
                $display("FAIL ctrl_word cycle=%0d actual=%05h required=%05h (state act=%0d req=%0d)",
                         cycle_no, act_word, exp_w, act_word[19:16], exp_w[19:16]);
            end
            if (bus.memRead === 1'b1 && bus.memWrite === 1'b1) begin
                failures++;
                $display("FAIL rd_wr_exclusive cycle=%0d actual=11 required=not both", cycle_no);
            end
        end
    end

    // Driver: apply one cycle of inputs and queue what the DUT must show.
    task automatic cyc(input logic rst_i, input logic [6:0] op,
                       input logic rdy, input logic [19:0] exp_w);
        reset        = rst_i;
        bus.opcode   = op;
        bus.memReady = rdy;
        exp_q.push_back(exp_w);
        @(posedge clk);
        #1;
        cycle_no++;
    endtask

    initial begin
        reset        = 1'b1;
        bus.opcode   = 7'd0;
        bus.memReady = 1'b0;
        @(posedge clk);
        #1;
        // Second reset cycle: state already FETCH.
        cyc(1, T_R, 0, W_FETCH_WT);

        // R-type, memReady tied high: 0,1,6,7
        cyc(0, T_R, 1, W_FETCH_GO);
        cyc(0, T_R, 1, W_DECODE);
        cyc(0, T_R, 1, W_EXECUTE);
        cyc(0, T_R, 1, W_ALUWB);

        // ld with three MEMREAD wait cycles: 8 cycles total
        cyc(0, T_LD, 1, W_FETCH_GO);
        cyc(0, T_LD, 0, W_DECODE);
        cyc(0, T_LD, 0, W_MEMADR);
        cyc(0, T_LD, 0, W_MEMREAD);
        cyc(0, T_LD, 0, W_MEMREAD);
        cyc(0, T_LD, 0, W_MEMREAD);
        cyc(0, T_LD, 1, W_MEMREAD);
        cyc(0, T_LD, 1, W_MEMWB);

        // sd with one MEMWRITE wait
        cyc(0, T_SD, 1, W_FETCH_GO);
        cyc(0, T_SD, 1, W_DECODE);
        cyc(0, T_SD, 1, W_MEMADR);
        cyc(0, T_SD, 0, W_MEMWR_WT);
        cyc(0, T_SD, 1, W_MEMWR_GO);

        // sd with no waits: 0,1,2,5
        cyc(0, T_SD, 1, W_FETCH_GO);
        cyc(0, T_SD, 1, W_DECODE);
        cyc(0, T_SD, 1, W_MEMADR);
        cyc(0, T_SD, 1, W_MEMWR_GO);

        // beq with one FETCH wait: 0,0,1,8
        cyc(0, T_BEQ, 0, W_FETCH_WT);
        cyc(0, T_BEQ, 1, W_FETCH_GO);
        cyc(0, T_BEQ, 1, W_DECODE);
        cyc(0, T_BEQ, 1, W_BRANCH);

        // Illegal opcode: TRAP is absorbing regardless of memReady
        cyc(0, T_BAD, 1, W_FETCH_GO);
        cyc(0, T_BAD, 1, W_DECODE);
        for (int i = 0; i < 20; i++) begin
            cyc(0, T_BAD, i[0], W_TRAP);
        end
        cyc(1, T_BAD, 1, W_TRAP);
        cyc(0, T_R, 0, W_FETCH_WT);

        // Reset during MEMREAD wait: back to FETCH, no write-back
        cyc(0, T_LD, 1, W_FETCH_GO);
        cyc(0, T_LD, 1, W_DECODE);
        cyc(0, T_LD, 0, W_MEMADR);
        cyc(0, T_LD, 0, W_MEMREAD);
        cyc(1, T_LD, 1, W_MEMREAD);
        cyc(0, T_LD, 1, W_FETCH_GO);
        cyc(0, T_LD, 1, W_DECODE);
        cyc(0, T_LD, 1, W_MEMADR);
        cyc(0, T_LD, 1, W_MEMREAD);
        cyc(0, T_LD, 1, W_MEMWB);
        cyc(0, T_R, 1, W_FETCH_GO);

        // Drain: every queued word must have been consumed.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style main control FSM for the multicycle RV64 subset core: ld, sd, R-type add/sub/and/or, beq.
- Sequences the shared ALU, memory, IR, PC and register file across states.
- Drives the 2-bit aluOp consumed by alu_control: 00 add, 01 sub, 10 decode funct fields.
- Waits on a memory-ready handshake and traps on illegal opcodes.

Parameters:
- OP_LD, 7'b0000011, load opcode
- OP_SD, 7'b0100011, store opcode
- OP_R, 7'b0110011, R-type opcode
- OP_BEQ, 7'b1100011, branch opcode

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- opcode  input  7  IR[6:0], stable from DECODE onward
- memReady  input  1  memory completes read/write this cycle
- pcWrite  output  1  unconditional PC load
- pcWriteCond  output  1  PC load if ALU zero
- pcSource  output  1  0 = ALU result, 1 = ALUOut
- iorD  output  1  0 = PC address, 1 = ALUOut address
- memRead  output  1  memory read request
- memWrite  output  1  memory write request
- irWrite  output  1  IR load
- memToReg  output  1  0 = ALUOut, 1 = MDR
- regWrite  output  1  register file write
- aluSrcA  output  1  0 = PC, 1 = rs1
- aluSrcB  output  2  00 = rs2, 01 = const 4, 10 = imm
- aluOp  output  2  to alu_control
- instrDone  output  1  one-cycle retire pulse
- illegal  output  1  trap indicator, sticky until reset
- state  output  4  current state, debug

Behaviour:
- Reset and interface: one clock; reset is synchronous and active-high. Reset forces state = FETCH. All outputs decode combinationally from state, opcode and memReady. Any output not listed for a state is 0.
- FETCH(0): memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=0; irWrite=pcWrite=memReady.
  - memReady=1 -> DECODE; else hold, requests held.
- DECODE(1): aluSrcA=0, aluSrcB=10, aluOp=00 (branch target into ALUOut).
  - ld/sd -> MEMADR; R -> EXECUTE; beq -> BRANCH; other -> TRAP.
- MEMADR(2): aluSrcA=1, aluSrcB=10, aluOp=00.
  - ld -> MEMREAD; sd -> MEMWRITE.
- MEMREAD(3): memRead=1, iorD=1.
  - memReady -> MEMWB; else hold.
- MEMWB(4): regWrite=1, memToReg=1, instrDone=1 -> FETCH.
- MEMWRITE(5): memWrite=1, iorD=1; instrDone=memReady.
  - memReady -> FETCH; else hold.
- EXECUTE(6): aluSrcA=1, aluSrcB=00, aluOp=10 -> ALUWB.
- ALUWB(7): regWrite=1, memToReg=0, instrDone=1 -> FETCH.
- BRANCH(8): aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=1, instrDone=1 -> FETCH.
- TRAP(9): illegal=1, all other outputs 0, absorbing; only reset exits.
- Unused encodings 10-15 -> TRAP next cycle.
- Latency with memReady tied 1: ld 5 cycles, sd 4, R 4, beq 3. Each memReady=0 cycle in FETCH/MEMREAD/MEMWRITE adds one cycle.
- memRead and memWrite are never both 1. regWrite is never 1 in a memory-wait state.
- Reset asserted mid-instruction: next edge state = FETCH, no partial writes issued on the reset cycle's successor.
- memReady asserted outside memory states is ignored.

Decomposition:
- Shared package (riscv_pkg): opcode constants, state encodings, aluOp codes (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10), aluSrcB select codes.
- Optional sub-module: multicycle_control_decode, purely combinational state/opcode -> control-word table. The FSM register and next-state logic stay in the top.

Test Plan:
- Reset held 2 cycles, then released with memReady=1 and opcode=OP_R -> states 0,1,6,7,0; aluOp=10 in state 6; regWrite=1 only in state 7; instrDone pulses once.
- opcode=OP_LD, memReady=0 for 3 cycles in MEMREAD -> state 3 held 4 cycles, memRead=iorD=1 throughout, then MEMWB with memToReg=1; total 8 cycles.
- opcode=OP_SD, memReady=1 -> states 0,1,2,5,0; memWrite=1 only in state 5; regWrite never 1.
- opcode=OP_BEQ -> states 0,1,8,0; state 8 has aluOp=01, pcWriteCond=1, pcSource=1; FETCH has pcWrite=1, aluSrcB=01.
- opcode=7'b1111111 -> TRAP after DECODE; illegal=1 held for 20 cycles, memRead=memWrite=0; reset -> FETCH with illegal=0.
- Reset asserted during MEMREAD wait -> next state FETCH; no regWrite pulse observed.
